nxn_matrix_multiplier: RTL and testbench

Parametrised successor to the team's fixed 2x2 matrix multiplier. Multiplies two NxN signed fixed-point matrices with one time-shared multiply-accumulate unit. It keeps the same Start/Stable/AB_Ack/C_Ack handshake as the 2x2 block, and adds saturation, an overflow flag and an accumulate mode (C = A*B + C_prev). It sits between the operand-loader and the result consumer in the matrix datapath.

---
 rtl/matmul_pkg.sv | 56 +++++
 rtl/mac_unit.sv | 69 ++++++
 rtl/nxn_matrix_multiplier.sv | 185 ++++++++++++++++++
 tb/tb_nxn_matrix_multiplier.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the NxN matrix multiplier.
// Provides the FSM state enum, index/accumulator width helpers, element
// packing helper and a signed saturation function on a wide carrier type.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Carrier wide enough for any accumulator up to DATA_W of about 120 bits.
    localparam int unsigned WIDE_W = 256;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Ceiling log2, at least 0; used for index and select widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Sum of N full-width products plus a shifted previous result never wraps.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned data_w);
        return 2 * data_w + clog2(n) + 1;
    endfunction

    // LSB position of element (r,c) in a packed row-major matrix vector.
    function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned data_w);
        return (r * n + c) * data_w;
    endfunction

    // Clamp a signed wide value into the data_w-bit two's complement range.
    function automatic wide_t saturate(input wide_t v, input int unsigned data_w);
        wide_t lim_hi;
        wide_t lim_lo;
        wide_t res;
        lim_hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
        lim_lo = -(wide_t'(1) <<< (data_w - 1));
        res    = v;
        if (v > lim_hi) begin
            res = lim_hi;
        end else if (v < lim_lo) begin
            res = lim_lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Time-shared multiply-accumulate for one result element at a time.
// Ports: clk/rst (sync, active-high); clr clears the accumulator; en adds
// a*b each cycle; last marks the final product of an element, at which point
// result_c/sat_c carry the shifted, saturated element and the accumulator
// clears. acc_mode adds c_prev (scaled by FRAC_W) into the final sum.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              last,
    input  logic              acc_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c_prev,
    output logic [DATA_W-1:0] result_c,
    output logic              sat_c
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = acc_width(N, DATA_W);

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  step_c;
    logic signed [ACC_W-1:0]  cprev_term_c;
    logic signed [ACC_W-1:0]  sum_c;
    wide_t                    shifted_c;
    wide_t                    clamped_c;

    // Product, final sum, floor shift and clamp; accumulator next value.
    always_comb begin
        prod_c       = PROD_W'(signed'(a)) * PROD_W'(signed'(b));
        step_c       = acc_q + ACC_W'(prod_c);
        cprev_term_c = '0;
        if (acc_mode) begin
            // Previous result is in output scale; lift it to product scale.
            cprev_term_c = ACC_W'(signed'(c_prev)) <<< FRAC_W;
        end
        sum_c     = step_c + cprev_term_c;
        shifted_c = WIDE_W'(sum_c) >>> FRAC_W;
        clamped_c = saturate(shifted_c, DATA_W);
        sat_c     = (clamped_c != shifted_c);
        result_c  = clamped_c[DATA_W-1:0];

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = last ? '0 : step_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/nxn_matrix_multiplier.sv
// NxN signed fixed-point matrix multiplier using one shared MAC.
// Ports: input_Clk, input_Reset (sync, active-high); input_Start/input_Stable
// launch a job capturing input_A/input_B/input_Accumulate; output_AB_Ack pulses
// on capture; output_C/output_Stable/output_Overflow present the result until
// input_C_Ack; output_Busy is high outside IDLE.
module nxn_matrix_multiplier
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 0
) (
    input  logic                    input_Clk,
    input  logic                    input_Reset,
    input  logic                    input_Start,
    input  logic                    input_Stable,
    input  logic                    input_Accumulate,
    input  logic                    input_C_Ack,
    input  logic [N*N*DATA_W-1:0]   input_A,
    input  logic [N*N*DATA_W-1:0]   input_B,
    output logic                    output_AB_Ack,
    output logic                    output_Stable,
    output logic                    output_Busy,
    output logic                    output_Overflow,
    output logic [N*N*DATA_W-1:0]   output_C
);

    localparam int unsigned IDX_W = clog2(N);
    localparam int unsigned VEC_W = N * N * DATA_W;
    localparam int unsigned SEL_W = clog2(VEC_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [VEC_W-1:0]   a_q, a_d, b_q, b_d, cbuf_q, cbuf_d, c_q, c_d;
    logic               accum_q, accum_d;
    logic               ab_ack_q, ab_ack_d;
    logic               stable_q, stable_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic               mac_clr_c, mac_en_c, last_k_c, sat_c;
    logic [SEL_W-1:0]   a_lsb_c, b_lsb_c, wr_lsb_c;
    logic [DATA_W-1:0]  a_el_c, b_el_c, cprev_el_c, res_c;

    // Operand and writeback element selection from the current indices.
    always_comb begin
        a_lsb_c    = SEL_W'(elem_lsb(32'(i_q), 32'(k_q), N, DATA_W));
        b_lsb_c    = SEL_W'(elem_lsb(32'(k_q), 32'(j_q), N, DATA_W));
        wr_lsb_c   = SEL_W'(elem_lsb(32'(i_q), 32'(j_q), N, DATA_W));
        a_el_c     = a_q[a_lsb_c +: DATA_W];
        b_el_c     = b_q[b_lsb_c +: DATA_W];
        cprev_el_c = c_q[wr_lsb_c +: DATA_W];
        last_k_c   = (k_q == LAST);
    end

    mac_unit #(
        .N      (N),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk      (input_Clk),
        .rst      (input_Reset),
        .clr      (mac_clr_c),
        .en       (mac_en_c),
        .last     (last_k_c),
        .acc_mode (accum_q),
        .a        (a_el_c),
        .b        (b_el_c),
        .c_prev   (cprev_el_c),
        .result_c (res_c),
        .sat_c    (sat_c)
    );

    // Next-state, index walk (k fastest, then j, then i) and buffer updates.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        cbuf_d    = cbuf_q;
        c_d       = c_q;
        accum_d   = accum_q;
        ovf_d     = ovf_q;
        ab_ack_d  = 1'b0;
        mac_clr_c = 1'b0;
        mac_en_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (input_Start && input_Stable) begin
                    a_d       = input_A;
                    b_d       = input_B;
                    accum_d   = input_Accumulate;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    ovf_d     = 1'b0;
                    ab_ack_d  = 1'b1;
                    mac_clr_c = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                mac_en_c = 1'b1;
                if (last_k_c) begin
                    cbuf_d[wr_lsb_c +: DATA_W] = res_c;
                    if (sat_c) begin
                        ovf_d = 1'b1;
                    end
                end
                if (last_k_c) begin
                    k_d = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            // Publish including the element written this cycle.
                            c_d     = cbuf_d;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + IDX_W'(1);
                        end
                    end else begin
                        j_d = j_q + IDX_W'(1);
                    end
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (input_C_Ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stable_d = (state_d == DONE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cbuf_q   <= '0;
            c_q      <= '0;
            accum_q  <= 1'b0;
            ab_ack_q <= 1'b0;
            stable_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cbuf_q   <= cbuf_d;
            c_q      <= c_d;
            accum_q  <= accum_d;
            ab_ack_q <= ab_ack_d;
            stable_q <= stable_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign output_AB_Ack   = ab_ack_q;
    assign output_Stable   = stable_q;
    assign output_Busy     = busy_q;
    assign output_Overflow = ovf_q;
    assign output_C        = c_q;

endmodule

// File: tb/tb_nxn_matrix_multiplier.sv
// Directed bench for nxn_matrix_multiplier: integer 2x2, fixed-point 2x2
// (FRAC_W=16) and integer 3x3 instances with hand-computed expectations.
module tb_nxn_matrix_multiplier;

    localparam int unsigned DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stable_in;
    logic             accum;
    logic [2:0]       start;
    logic [2:0]       cack;
    logic [2:0]       ab_ack;
    logic [2:0]       st_out;
    logic [2:0]       busy;
    logic [2:0]       ovf;
    logic [4*DW-1:0]  a2, b2, c2, aq, bq, cq;
    logic [9*DW-1:0]  a3, b3, c3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nxn_matrix_multiplier #(.N(2), .DATA_W(32), .FRAC_W(0)) dut (
        .input_Clk(clk), .input_Reset(rst), .input_Start(start[0]),
        .input_Stable(stable_in), .input_Accumulate(accum), .input_C_Ack(cack[0]),
        .input_A(a2), .input_B(b2), .output_AB_Ack(ab_ack[0]),
        .output_Stable(st_out[0]), .output_Busy(busy[0]),
        .output_Overflow(ovf[0]), .output_C(c2)
    );

    nxn_matrix_multiplier #(.N(2), .DATA_W(32), .FRAC_W(16)) dut_q (
        .input_Clk(clk), .input_Reset(rst), .input_Start(start[1]),
        .input_Stable(stable_in), .input_Accumulate(accum), .input_C_Ack(cack[1]),
        .input_A(aq), .input_B(bq), .output_AB_Ack(ab_ack[1]),
        .output_Stable(st_out[1]), .output_Busy(busy[1]),
        .output_Overflow(ovf[1]), .output_C(cq)
    );

    nxn_matrix_multiplier #(.N(3), .DATA_W(32), .FRAC_W(0)) dut3 (
        .input_Clk(clk), .input_Reset(rst), .input_Start(start[2]),
        .input_Stable(stable_in), .input_Accumulate(accum), .input_C_Ack(cack[2]),
        .input_A(a3), .input_B(b3), .output_AB_Ack(ab_ack[2]),
        .output_Stable(st_out[2]), .output_Busy(busy[2]),
        .output_Overflow(ovf[2]), .output_C(c3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] el(input logic [9*DW-1:0] v, input int idx);
        return v[idx*DW +: DW];
    endfunction

    function automatic logic [9*DW-1:0] get_c(input int sel);
        if (sel == 0) return (9*DW)'(c2);
        if (sel == 1) return (9*DW)'(cq);
        return c3;
    endfunction

    // Launch a job on instance sel; lat = edges from accept to first Stable.
    // noisy keeps Start high and scrambles operands of instance 0 during MAC.
    task automatic run_job(input int sel, input bit acc, input bit noisy, output int lat);
        int l;
        int extra;
        accum      = acc;
        stable_in  = 1'b1;
        start[sel] = 1'b1;
        @(posedge clk); #1;
        l = 1;
        check("ab_ack_pulse", 32'(ab_ack[sel]), 32'd1);
        check("busy_in_mac", 32'(busy[sel]), 32'd1);
        if (noisy) begin
            a2 = '1;
            b2 = {4{32'h1234_5678}};
        end else begin
            start[sel] = 1'b0;
            stable_in  = 1'b0;
        end
        extra = 0;
        while (!st_out[sel] && l < 200) begin
            @(posedge clk); #1;
            l++;
            if (ab_ack[sel]) extra++;
        end
        start[sel] = 1'b0;
        stable_in  = 1'b0;
        check("ab_ack_once", 32'(extra), 32'd0);
        lat = l;
    endtask

    task automatic ack(input int sel);
        cack[sel] = 1'b1;
        @(posedge clk); #1;
        cack[sel] = 1'b0;
        check("stable_drop_after_ack", 32'(st_out[sel]), 32'd0);
        check("idle_after_ack", 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int drop;
        logic [9*DW-1:0] c;

        rst = 1'b1; stable_in = 1'b0; accum = 1'b0; start = '0; cack = '0;
        a2 = '0; b2 = '0; aq = '0; bq = '0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stable", 32'(st_out[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_ab_ack", 32'(ab_ack[0]), 32'd0);
        check("rst_ovf", 32'(ovf[0]), 32'd0);
        check("rst_c00", el(get_c(0), 0), 32'd0);
        rst = 1'b0;

        // Start without Stable is ignored.
        start[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("nostable_ab_ack", 32'(ab_ack[0]), 32'd0);
        check("nostable_busy", 32'(busy[0]), 32'd0);
        start[0] = 1'b0;

        // Basic integer product, then hold Stable for 20 cycles.
        a2 = {32'd4, 32'd3, 32'd2, 32'd1};
        b2 = {32'd8, 32'd7, 32'd6, 32'd5};
        run_job(0, 1'b0, 1'b0, lat);
        check("lat_2x2", 32'(lat), 32'd9);
        c = get_c(0);
        check("basic_c00", el(c, 0), 32'd19);
        check("basic_c01", el(c, 1), 32'd22);
        check("basic_c10", el(c, 2), 32'd43);
        check("basic_c11", el(c, 3), 32'd50);
        check("basic_ovf", 32'(ovf[0]), 32'd0);
        drop = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!st_out[0]) drop++;
        end
        check("stable_hold", 32'(drop), 32'd0);
        ack(0);
        check("c_retained", el(get_c(0), 3), 32'd50);

        // Accumulate onto the previous result.
        run_job(0, 1'b1, 1'b0, lat);
        c = get_c(0);
        check("accum_c00", el(c, 0), 32'd38);
        check("accum_c01", el(c, 1), 32'd44);
        check("accum_c10", el(c, 2), 32'd86);
        check("accum_c11", el(c, 3), 32'd100);
        ack(0);

        // Positive and negative saturation.
        a2 = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
        b2 = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
        run_job(0, 1'b0, 1'b0, lat);
        check("satpos_c00", el(get_c(0), 0), 32'h7FFF_FFFF);
        check("satpos_c01", el(get_c(0), 1), 32'd0);
        check("satpos_ovf", 32'(ovf[0]), 32'd1);
        ack(0);
        a2 = {32'd0, 32'd0, 32'd0, 32'h8000_0000};
        run_job(0, 1'b0, 1'b0, lat);
        check("satneg_c00", el(get_c(0), 0), 32'h8000_0000);
        check("satneg_ovf", 32'(ovf[0]), 32'd1);
        ack(0);

        // Start held and operands scrambled during MAC: no effect on the job.
        a2 = {32'd4, 32'd3, 32'd2, 32'd1};
        b2 = {32'd8, 32'd7, 32'd6, 32'd5};
        run_job(0, 1'b0, 1'b1, lat);
        c = get_c(0);
        check("noisy_c00", el(c, 0), 32'd19);
        check("noisy_c11", el(c, 3), 32'd50);
        check("ovf_cleared", 32'(ovf[0]), 32'd0);

        // Start coincident with C_Ack is not accepted.
        start[0] = 1'b1; stable_in = 1'b1; cack[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; stable_in = 1'b0; cack[0] = 1'b0;
        check("start_with_ack_ab_ack", 32'(ab_ack[0]), 32'd0);
        check("start_with_ack_idle", 32'(busy[0]), 32'd0);

        // Fixed point: 1.5 * 2.0 and floor rounding of -2^-16 * 0.5.
        aq = {32'd0, 32'd0, 32'd0, 32'h0001_8000};
        bq = {32'd0, 32'd0, 32'd0, 32'h0002_0000};
        run_job(1, 1'b0, 1'b0, lat);
        check("q16_lat", 32'(lat), 32'd9);
        check("q16_c00", el(get_c(1), 0), 32'h0003_0000);
        check("q16_ovf", 32'(ovf[1]), 32'd0);
        ack(1);
        aq = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        bq = {32'd0, 32'd0, 32'd0, 32'h0000_8000};
        run_job(1, 1'b0, 1'b0, lat);
        check("q16_floor_c00", el(get_c(1), 0), 32'hFFFF_FFFF);
        ack(1);

        // Reset in MAC cycle 4 clears everything.
        start[0] = 1'b1; stable_in = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; stable_in = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_stable", 32'(st_out[0]), 32'd0);
        check("midrst_ab_ack", 32'(ab_ack[0]), 32'd0);
        check("midrst_c00", el(get_c(0), 0), 32'd0);

        // 3x3 with identity B returns A.
        for (int e = 0; e < 9; e++) begin
            a3[e*DW +: DW] = 32'(e * 7 - 20);
            b3[e*DW +: DW] = (e % 4 == 0) ? 32'd1 : 32'd0;
        end
        run_job(2, 1'b0, 1'b0, lat);
        check("lat_3x3", 32'(lat), 32'd28);
        c = get_c(2);
        for (int e = 0; e < 9; e++) begin
            check($sformatf("ident_c%0d", e), el(c, e), 32'(e * 7 - 20));
        end
        ack(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
